// File: rtl/booth_pkg.sv
// Shared radix-4 Booth code definitions: bit positions, digit codes,
// lowest-row codes and the encoder FSM state type.
package booth_pkg;

  localparam int BOOTH_NEG = 2;
  localparam int BOOTH_TWO = 1;
  localparam int BOOTH_ONE = 0;

  localparam logic [2:0] BC_ZERO = 3'b000;
  localparam logic [2:0] BC_P1   = 3'b001;
  localparam logic [2:0] BC_P2   = 3'b010;
  localparam logic [2:0] BC_M1   = 3'b101;
  localparam logic [2:0] BC_M2   = 3'b110;

  // Lowest-row form {NEG,ONE}: +2 cannot occur there because y(-1) is 0.
  localparam logic [1:0] BL_ZERO = 2'b00;
  localparam logic [1:0] BL_P1   = 2'b01;
  localparam logic [1:0] BL_M2   = 2'b10;
  localparam logic [1:0] BL_M1   = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_e;

  function automatic logic [1:0] booth_lo(input logic [2:0] code);
    return {code[BOOTH_NEG], code[BOOTH_ONE]};
  endfunction

endpackage

// File: rtl/booth_digit_enc.sv
// Combinational radix-4 Booth digit encoder: one overlapping bit triple
// {y(2i+1),y(2i),y(2i-1)} in, full and lowest-row digit codes out.
module booth_digit_enc
  import booth_pkg::*;
(
  input  logic [2:0] triple_i,
  output logic [2:0] code_o,
  output logic [1:0] code_lo_o
);

  always_comb begin
    code_o = BC_ZERO;
    unique case (triple_i)
      3'b000:  code_o = BC_ZERO;
      3'b001:  code_o = BC_P1;
      3'b010:  code_o = BC_P1;
      3'b011:  code_o = BC_P2;
      3'b100:  code_o = BC_M2;
      3'b101:  code_o = BC_M1;
      3'b110:  code_o = BC_M1;
      3'b111:  code_o = BC_ZERO; // no negative zero
      default: code_o = BC_ZERO;
    endcase
  end

  assign code_lo_o = booth_lo(code_o);

endmodule

// File: rtl/booth_encoder_seq.sv
// Sequential radix-4 Booth encoder: loads a signed multiplier, then streams
// one registered Booth digit per out handshake, least significant first.
module booth_encoder_seq
  import booth_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int IDX_W = ((WIDTH / 2) > 1) ? $clog2(WIDTH / 2) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       out_code,
  output logic [1:0]       out_code_lo,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last
);

  localparam int             NUM_DIGITS = WIDTH / 2;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  state_e             state_q, state_d;
  logic [WIDTH:0]     sr_q, sr_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               last_q, last_d;
  logic [2:0]         code_q, code_d;
  logic [1:0]         lo_q, lo_d;

  logic               load, advance, finish;
  logic [2:0]         triple_sel;
  logic [2:0]         enc_code;
  logic [1:0]         enc_lo;

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (in_valid)             state_d = ST_EMIT;
      ST_EMIT: if (out_ready && last_q)  state_d = ST_IDLE;
      default:                           state_d = ST_IDLE;
    endcase
  end

  // FSM: handshake outputs depend on state only
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      ST_IDLE: in_ready  = 1'b1;
      ST_EMIT: out_valid = 1'b1;
      default: in_ready  = 1'b0;
    endcase
  end

  assign load    = in_valid & in_ready;
  assign advance = out_valid & out_ready & ~last_q;
  assign finish  = out_valid & out_ready & last_q;

  // The encoder looks at the triple that will be current after this edge,
  // so the digit outputs can be registered without an extra cycle.
  assign triple_sel = load ? {in_b[1:0], 1'b0} : sr_q[4:2];

  booth_digit_enc u_enc (
    .triple_i  (triple_sel),
    .code_o    (enc_code),
    .code_lo_o (enc_lo)
  );

  always_comb begin
    sr_d   = sr_q;
    idx_d  = idx_q;
    last_d = last_q;
    code_d = code_q;
    lo_d   = lo_q;
    if (load) begin
      sr_d   = {in_b, 1'b0};
      idx_d  = '0;
      last_d = 1'b0;
      code_d = enc_code;
      lo_d   = enc_lo;
    end else if (advance) begin
      sr_d   = {{2{sr_q[WIDTH]}}, sr_q[WIDTH:2]};
      idx_d  = idx_q + IDX_W'(1);
      last_d = ((idx_q + IDX_W'(1)) == LAST_IDX);
      code_d = enc_code;
      lo_d   = enc_lo;
    end else if (finish) begin
      idx_d  = '0;
      last_d = 1'b0;
      code_d = BC_ZERO;
      lo_d   = BL_ZERO;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q   <= '0;
      idx_q  <= '0;
      last_q <= 1'b0;
      code_q <= BC_ZERO;
      lo_q   <= BL_ZERO;
    end else begin
      sr_q   <= sr_d;
      idx_q  <= idx_d;
      last_q <= last_d;
      code_q <= code_d;
      lo_q   <= lo_d;
    end
  end

  assign out_code    = code_q;
  assign out_code_lo = lo_q;
  assign out_idx     = idx_q;
  assign out_last    = last_q;

endmodule

// File: tb/tb_booth_encoder_seq.sv
// Directed bench for booth_encoder_seq (WIDTH=8): hand-computed digit
// streams, backpressure, busy-input rejection, mid-stream reset, random sums.
module tb_booth_encoder_seq;

  localparam int WIDTH = 8;
  localparam int IDX_W = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_b = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [2:0]       out_code;
  logic [1:0]       out_code_lo;
  logic [IDX_W-1:0] out_idx;
  logic             out_last;

  int total = 0;
  int bad   = 0;

  booth_encoder_seq #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_b        (in_b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_code    (out_code),
    .out_code_lo (out_code_lo),
    .out_idx     (out_idx),
    .out_last    (out_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int digit_val(input logic [2:0] c);
    int m;
    m = c[1] ? 2 : (c[0] ? 1 : 0);
    return c[2] ? -m : m;
  endfunction

  // Present B for one cycle (inputs driven at negedge, away from posedge).
  task automatic send(input string tag, input logic [7:0] b);
    chk($sformatf("%s in_ready_before", tag), int'(in_ready), 1);
    in_valid = 1'b1;
    in_b     = b;
    @(negedge clk);
    in_valid = 1'b0;
    in_b     = 8'hA5;
  endtask

  // Check one digit at the current negedge.
  task automatic chk_digit(input string tag, input int i, input logic use_exp,
                           input logic [2:0] exp_code);
    chk($sformatf("%s d%0d valid", tag, i), int'(out_valid), 1);
    chk($sformatf("%s d%0d in_ready", tag, i), int'(in_ready), 0);
    chk($sformatf("%s d%0d idx", tag, i), int'(out_idx), i);
    chk($sformatf("%s d%0d last", tag, i), int'(out_last), (i == 3) ? 1 : 0);
    if (use_exp) begin
      chk($sformatf("%s d%0d code", tag, i), int'(out_code), int'(exp_code));
      if (i == 0)
        chk($sformatf("%s d0 lo", tag), int'(out_code_lo),
            int'({exp_code[2], exp_code[0]}));
    end
  endtask

  // Stream all four digits with out_ready=1; codes packed d3..d0.
  task automatic run_b(input string tag, input logic [7:0] b,
                       input logic use_exp, input logic [11:0] codes);
    int sum;
    sum = 0;
    send(tag, b);
    for (int i = 0; i < 4; i++) begin
      chk_digit(tag, i, use_exp, codes[3*i +: 3]);
      sum += digit_val(out_code) * (1 << (2 * i));
      @(negedge clk);
    end
    chk($sformatf("%s sum", tag), sum, int'($signed(b)));
    chk($sformatf("%s in_ready_after", tag), int'(in_ready), 1);
    chk($sformatf("%s valid_after", tag), int'(out_valid), 0);
    $display("txn %s B=%02h sum=%0d", tag, b, sum);
  endtask

  initial begin
    logic [2:0] held_code;
    logic [7:0] rb;

    // Reset state
    @(negedge clk);
    chk("rst in_ready", int'(in_ready), 1);
    chk("rst out_valid", int'(out_valid), 0);
    chk("rst code", int'(out_code), 0);
    chk("rst lo", int'(out_code_lo), 0);
    chk("rst idx", int'(out_idx), 0);
    chk("rst last", int'(out_last), 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_b("b00", 8'h00, 1'b1, {3'b000, 3'b000, 3'b000, 3'b000});
    run_b("bFF", 8'hFF, 1'b1, {3'b000, 3'b000, 3'b000, 3'b101});
    run_b("b7F", 8'h7F, 1'b1, {3'b010, 3'b000, 3'b000, 3'b101});
    run_b("b80", 8'h80, 1'b1, {3'b110, 3'b000, 3'b000, 3'b000});
    run_b("b02", 8'h02, 1'b1, {3'b000, 3'b000, 3'b001, 3'b110});
    run_b("b55", 8'h55, 1'b1, {3'b001, 3'b001, 3'b001, 3'b001});
    run_b("b03", 8'h03, 1'b1, {3'b000, 3'b000, 3'b001, 3'b101});

    // Backpressure at idx 1 of 7F, with in_valid pulses while busy
    send("bp", 8'h7F);
    chk_digit("bp", 0, 1'b1, 3'b101);
    @(negedge clk);
    out_ready = 1'b0;
    held_code = 3'b000;
    for (int k = 0; k < 3; k++) begin
      chk_digit($sformatf("bp hold%0d", k), 1, 1'b1, held_code);
      in_valid = k[0] ? 1'b0 : 1'b1;
      in_b     = 8'h80;
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk_digit("bp", 1, 1'b1, 3'b000);
    @(negedge clk);
    chk_digit("bp", 2, 1'b1, 3'b000);
    @(negedge clk);
    chk_digit("bp", 3, 1'b1, 3'b010);
    @(negedge clk);
    chk("bp in_ready_after", int'(in_ready), 1);
    $display("txn bp B=7f stalled 3 cycles at idx1");

    // Reset asserted while at idx 2
    send("rst_mid", 8'h7F);
    chk_digit("rst_mid", 0, 1'b1, 3'b101);
    @(negedge clk);
    chk_digit("rst_mid", 1, 1'b1, 3'b000);
    @(negedge clk);
    chk_digit("rst_mid", 2, 1'b1, 3'b000);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid out_valid", int'(out_valid), 0);
    chk("rst_mid in_ready", int'(in_ready), 1);
    chk("rst_mid code", int'(out_code), 0);
    chk("rst_mid lo", int'(out_code_lo), 0);
    chk("rst_mid idx", int'(out_idx), 0);
    chk("rst_mid last", int'(out_last), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mid released valid", int'(out_valid), 0);
    $display("txn rst_mid aborted at idx2");
    run_b("post_rst", 8'h80, 1'b1, {3'b110, 3'b000, 3'b000, 3'b000});

    // Random multipliers checked through the digit sum
    for (int r = 0; r < 8; r++) begin
      rb = 8'($urandom_range(0, 255));
      run_b($sformatf("rnd%0d", r), rb, 1'b0, 12'h000);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
